// File: rtl/rle_pkg.sv
// Shared types and constants for the RLE image loaders.
// Control byte: bit 7 selects literal/repeat, bits 6:0 hold the run length minus its minimum.
package rle_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CTRL     = 3'd1,
    LIT      = 3'd2,
    REP_VAL  = 3'd3,
    REP_FILL = 3'd4
  } state_t;

  localparam int PIXELS         = 320 * 240;
  localparam int RLE_REPEAT_BIT = 7;
  localparam int RLE_LEN_MSB    = 6;
  localparam int LIT_MIN        = 1;
  localparam int REP_MIN        = 2;

endpackage

// File: rtl/rle_vram_loader_if.sv
// HPS ioctl download port plus the VRAM write port and loader status.
// The master side drives the download stream; the slave side is the loader.
interface rle_vram_loader_if #(
  parameter int AW = 17
);
  logic          ioctl_download;
  logic          ioctl_wr;
  logic [7:0]    ioctl_data;
  logic          ioctl_wait;
  logic          vram_we;
  logic [AW-1:0] vram_addr;
  logic [7:0]    vram_data;
  logic          busy;
  logic          done;
  logic          overflow;
  logic          truncated;

  modport master (
    output ioctl_download, ioctl_wr, ioctl_data,
    input  ioctl_wait, vram_we, vram_addr, vram_data, busy, done, overflow, truncated
  );

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_data,
    output ioctl_wait, vram_we, vram_addr, vram_data, busy, done, overflow, truncated
  );
endinterface

// File: rtl/edge_detect.sv
// Rise/fall detector against the previous-cycle registered level; edges are valid in the
// cycle the input changes. No backpressure.
module edge_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic rise,
  output logic fall
);
  logic d_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) d_q <= 1'b0;
    else          d_q <= d;
  end

  assign rise = d & ~d_q;
  assign fall = ~d & d_q;
endmodule

// File: rtl/rle_vram_loader.sv
// RLE decoder from the HPS ioctl stream into linear RGB332 VRAM; literal pixels land one cycle
// after their strobe, repeats fill one pixel per clock while ioctl_wait stalls the HPS.
module rle_vram_loader #(
  parameter int AW     = 17,
  parameter int PIXELS = rle_pkg::PIXELS
) (
  input  logic             clk,
  input  logic             reset_n,
  rle_vram_loader_if.slave bus
);
  import rle_pkg::*;

  localparam logic [AW-1:0] ADDR_END = AW'(PIXELS);

  state_t        state, state_nx;
  logic [7:0]    cnt;
  logic [AW-1:0] addr;
  logic [7:0]    pix_dat;
  logic          pix_lit;
  logic          end_pend;
  logic          busy_q, done_q, overflow_q, truncated_q;
  logic          rise, fall;
  logic          wr;
  logic          pix_vld, pix_in_range;
  logic          done_nx, trunc_set, lit_take, val_take;

  edge_detect u_dl_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (bus.ioctl_download),
    .rise    (rise),
    .fall    (fall)
  );

  assign wr = bus.ioctl_wr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (rise) begin
      state_nx = CTRL;
    end else begin
      case (state)
        IDLE:     state_nx = IDLE;
        CTRL:     if (fall)    state_nx = IDLE;
                  else if (wr) state_nx = bus.ioctl_data[RLE_REPEAT_BIT] ? REP_VAL : LIT;
        LIT:      if (fall)                  state_nx = IDLE;
                  else if (wr && cnt == 8'd0) state_nx = CTRL;
        REP_VAL:  if (fall)    state_nx = IDLE;
                  else if (wr) state_nx = REP_FILL;
        // A download end seen mid-fill is held until the fill finishes
        REP_FILL: if (cnt == 8'd0) state_nx = (fall || end_pend) ? IDLE : CTRL;
        default:  state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    done_nx   = !rise && (state != IDLE) && (state_nx == IDLE);
    trunc_set = !rise && ((fall && (state == LIT || state == REP_VAL)) ||
                          (wr && state == REP_FILL));
    lit_take  = !rise && !fall && wr && (state == LIT);
    val_take  = !rise && !fall && wr && (state == REP_VAL);
  end

  assign pix_vld      = pix_lit || (state == REP_FILL);
  assign pix_in_range = addr < ADDR_END;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt         <= '0;
      addr        <= '0;
      pix_dat     <= '0;
      pix_lit     <= 1'b0;
      end_pend    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
      truncated_q <= 1'b0;
    end else begin
      busy_q <= (state_nx != IDLE);
      done_q <= done_nx;
      if (rise) begin
        addr        <= '0;
        pix_lit     <= 1'b0;
        end_pend    <= 1'b0;
        overflow_q  <= 1'b0;
        truncated_q <= 1'b0;
      end else begin
        pix_lit  <= lit_take;
        end_pend <= (state == REP_FILL) && (state_nx == REP_FILL) && (end_pend || fall);
        // Address stops at PIXELS; pixels beyond it are dropped but still decoded
        if (pix_vld) begin
          if (pix_in_range) addr <= addr + AW'(1);
          else              overflow_q <= 1'b1;
        end
        if (trunc_set) truncated_q <= 1'b1;
      end
      if (lit_take || val_take) pix_dat <= bus.ioctl_data;
      case (state)
        CTRL:     if (wr)           cnt <= {1'b0, bus.ioctl_data[RLE_LEN_MSB:0]};
        LIT:      if (lit_take)     cnt <= cnt - 8'd1;
        REP_VAL:  if (val_take)     cnt <= cnt + 8'(REP_MIN - LIT_MIN);
        REP_FILL: if (cnt != 8'd0)  cnt <= cnt - 8'd1;
        default:  cnt <= cnt;
      endcase
    end
  end

  assign bus.ioctl_wait = (state == REP_FILL);
  assign bus.vram_we    = pix_vld && pix_in_range;
  assign bus.vram_addr  = addr;
  assign bus.vram_data  = pix_dat;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.overflow   = overflow_q;
  assign bus.truncated  = truncated_q;
endmodule

// File: tb/tb_rle_vram_loader.sv
// Directed bench for rle_vram_loader: literal, repeat, overflow, truncation, end-in-fill,
// restart and reset-mid-fill scenarios against hand-computed VRAM write sequences.
module tb_rle_vram_loader;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  rle_vram_loader_if #(.AW(17)) bus ();

  rle_vram_loader #(.AW(17), .PIXELS(76800)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;

  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  last_strobe = 0;
  wr_t log_q[$];
  int  wait_cnt = 0;
  int  wait_first = 0;
  int  done_cnt = 0;
  int  done_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    wr_t e;
    if (bus.vram_we) begin
      e.addr = int'(bus.vram_addr);
      e.data = int'(bus.vram_data);
      e.cyc  = cyc;
      log_q.push_back(e);
    end
    if (bus.ioctl_wait) begin
      if (wait_cnt == 0) wait_first = cyc;
      wait_cnt++;
    end
    if (bus.done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    log_q.delete();
    wait_cnt = 0;
    wait_first = 0;
    done_cnt = 0;
    done_cyc = 0;
  endtask

  task automatic wait_fill_end();
    int n = 0;
    while (bus.ioctl_wait && n < 300) begin
      tick();
      n++;
    end
    if (bus.ioctl_wait) begin
      errors++;
      $display("FAIL wait_timeout: ioctl_wait still 1 after %0d cycles, want 0", n);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    wait_fill_end();
    last_strobe = cyc;
    bus.ioctl_wr   = 1'b1;
    bus.ioctl_data = b;
    tick();
    bus.ioctl_wr   = 1'b0;
  endtask

  task automatic start_dl();
    bus.ioctl_download = 1'b1;
    tick();
  endtask

  task automatic end_dl();
    bus.ioctl_download = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    logic [30:0] outs;
    reset_n = 1'b0;
    repeat (3) tick();
    outs = {bus.ioctl_wait, bus.vram_we, bus.vram_addr, bus.vram_data,
            bus.busy, bus.done, bus.overflow, bus.truncated};
    checks++;
    if (outs !== 31'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %0h want 0", outs);
    end
    reset_n = 1'b1;
    repeat (2) tick();
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset busy: got %0b want 0", bus.busy);
    end
  endtask

  task automatic test_literal();
    logic [7:0] exp_d [3];
    int s [3];
    exp_d[0] = 8'hAA; exp_d[1] = 8'hBB; exp_d[2] = 8'hCC;
    clear_mon();
    start_dl();
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL lit_busy: got %0b want 1", bus.busy);
    end
    send_byte(8'h02);
    for (int i = 0; i < 3; i++) begin
      send_byte(exp_d[i]);
      s[i] = last_strobe;
    end
    tick();
    end_dl();
    repeat (3) tick();
    checks++;
    if (log_q.size() !== 3) begin
      errors++;
      $display("FAIL lit_count: got %0d writes want 3", log_q.size());
    end
    for (int i = 0; i < 3 && i < log_q.size(); i++) begin
      checks++;
      if (log_q[i].addr !== i || log_q[i].data !== int'(exp_d[i]) || log_q[i].cyc !== s[i] + 1) begin
        errors++;
        $display("FAIL lit_write%0d: got addr %0d data %0h cyc %0d want addr %0d data %0h cyc %0d",
                 i, log_q[i].addr, log_q[i].data, log_q[i].cyc, i, exp_d[i], s[i] + 1);
      end
    end
    checks++;
    if (done_cnt !== 1 || bus.truncated !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL lit_end: got done %0d trunc %0b busy %0b want 1 0 0",
               done_cnt, bus.truncated, bus.busy);
    end
  endtask

  task automatic test_repeat();
    int v;
    clear_mon();
    start_dl();
    send_byte(8'h83);
    send_byte(8'h1C);
    v = last_strobe;
    repeat (8) tick();
    end_dl();
    repeat (3) tick();
    checks++;
    if (log_q.size() !== 5) begin
      errors++;
      $display("FAIL rep_count: got %0d writes want 5", log_q.size());
    end
    for (int i = 0; i < 5 && i < log_q.size(); i++) begin
      checks++;
      if (log_q[i].addr !== i || log_q[i].data !== 'h1C || log_q[i].cyc !== v + 1 + i) begin
        errors++;
        $display("FAIL rep_write%0d: got addr %0d data %0h cyc %0d want addr %0d data 1c cyc %0d",
                 i, log_q[i].addr, log_q[i].data, log_q[i].cyc, i, v + 1 + i);
      end
    end
    checks++;
    if (wait_cnt !== 5 || wait_first !== v + 1) begin
      errors++;
      $display("FAIL rep_wait: got %0d cycles from %0d want 5 from %0d", wait_cnt, wait_first, v + 1);
    end
    checks++;
    if (done_cnt !== 1) begin
      errors++;
      $display("FAIL rep_done: got %0d pulses want 1", done_cnt);
    end
  endtask

  task automatic test_overflow();
    clear_mon();
    start_dl();
    for (int i = 0; i < 595; i++) begin
      send_byte(8'hFF);
      send_byte(8'h5A);
    end
    send_byte(8'hA9);
    send_byte(8'h5A);
    wait_fill_end();
    checks++;
    if (bus.vram_addr !== 17'd76798 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_prefill: got addr %0d ovf %0b want 76798 0", bus.vram_addr, bus.overflow);
    end
    clear_mon();
    send_byte(8'h84);
    send_byte(8'hFF);
    wait_fill_end();
    tick();
    checks++;
    if (log_q.size() !== 2) begin
      errors++;
      $display("FAIL ovf_count: got %0d writes want 2", log_q.size());
    end
    for (int i = 0; i < 2 && i < log_q.size(); i++) begin
      checks++;
      if (log_q[i].addr !== 76798 + i || log_q[i].data !== 'hFF) begin
        errors++;
        $display("FAIL ovf_write%0d: got addr %0d data %0h want addr %0d data ff",
                 i, log_q[i].addr, log_q[i].data, 76798 + i);
      end
    end
    checks++;
    if (bus.overflow !== 1'b1 || bus.vram_addr !== 17'd76800 || wait_cnt !== 6) begin
      errors++;
      $display("FAIL ovf_state: got ovf %0b addr %0d wait %0d want 1 76800 6",
               bus.overflow, bus.vram_addr, wait_cnt);
    end
    end_dl();
    repeat (2) tick();
  endtask

  task automatic test_truncation();
    clear_mon();
    start_dl();
    checks++;
    if (bus.overflow !== 1'b0 || bus.vram_addr !== 17'd0) begin
      errors++;
      $display("FAIL restart_clear: got ovf %0b addr %0d want 0 0", bus.overflow, bus.vram_addr);
    end
    send_byte(8'h05);
    send_byte(8'h11);
    send_byte(8'h22);
    end_dl();
    repeat (3) tick();
    checks++;
    if (log_q.size() !== 2) begin
      errors++;
      $display("FAIL trunc_count: got %0d writes want 2", log_q.size());
    end else begin
      checks++;
      if (log_q[0].data !== 'h11 || log_q[1].data !== 'h22 || log_q[1].addr !== 1) begin
        errors++;
        $display("FAIL trunc_data: got %0h %0h @%0d want 11 22 @1",
                 log_q[0].data, log_q[1].data, log_q[1].addr);
      end
    end
    checks++;
    if (bus.truncated !== 1'b1 || done_cnt !== 1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL trunc_end: got trunc %0b done %0d busy %0b want 1 1 0",
               bus.truncated, done_cnt, bus.busy);
    end
  endtask

  task automatic test_end_during_fill();
    int v;
    int bad;
    int n;
    clear_mon();
    start_dl();
    checks++;
    if (bus.truncated !== 1'b0) begin
      errors++;
      $display("FAIL restart_trunc_clear: got %0b want 0", bus.truncated);
    end
    send_byte(8'hFF);
    send_byte(8'h55);
    v = last_strobe;
    repeat (10) tick();
    bus.ioctl_download = 1'b0;
    n = 0;
    while (done_cnt == 0 && n < 300) begin
      tick();
      n++;
    end
    tick();
    checks++;
    if (done_cnt !== 1) begin
      errors++;
      $display("FAIL fill_end_done: got %0d pulses want 1", done_cnt);
    end
    bad = 0;
    for (int i = 0; i < log_q.size(); i++)
      if (log_q[i].addr !== i || log_q[i].data !== 'h55) bad++;
    checks++;
    if (log_q.size() !== 129 || bad !== 0) begin
      errors++;
      $display("FAIL fill_end_writes: got %0d writes (%0d wrong) want 129 (0 wrong)", log_q.size(), bad);
    end
    checks++;
    if (done_cyc !== v + 130 || bus.truncated !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL fill_end_state: got done@%0d trunc %0b busy %0b want done@%0d 0 0",
               done_cyc, bus.truncated, bus.busy, v + 130);
    end
  endtask

  task automatic test_restart_mid_fill();
    clear_mon();
    start_dl();
    send_byte(8'h90);
    send_byte(8'h77);
    repeat (3) tick();
    end_dl();
    start_dl();
    checks++;
    if (bus.ioctl_wait !== 1'b0 || bus.busy !== 1'b1 || bus.vram_addr !== 17'd0) begin
      errors++;
      $display("FAIL restart_busy: got wait %0b busy %0b addr %0d want 0 1 0",
               bus.ioctl_wait, bus.busy, bus.vram_addr);
    end
    repeat (4) tick();
    checks++;
    if (done_cnt !== 0) begin
      errors++;
      $display("FAIL restart_no_done: got %0d pulses want 0", done_cnt);
    end
    clear_mon();
    send_byte(8'h00);
    send_byte(8'h99);
    tick();
    checks++;
    if (log_q.size() !== 1) begin
      errors++;
      $display("FAIL restart_write: got %0d writes want 1", log_q.size());
    end else begin
      checks++;
      if (log_q[0].addr !== 0 || log_q[0].data !== 'h99) begin
        errors++;
        $display("FAIL restart_write_val: got addr %0d data %0h want 0 99", log_q[0].addr, log_q[0].data);
      end
    end
    end_dl();
    repeat (2) tick();
  endtask

  task automatic test_reset_mid_fill();
    logic [30:0] outs;
    int n;
    clear_mon();
    start_dl();
    send_byte(8'hFF);
    send_byte(8'h33);
    repeat (20) tick();
    reset_n = 1'b0;
    bus.ioctl_download = 1'b0;
    #1;
    outs = {bus.ioctl_wait, bus.vram_we, bus.vram_addr, bus.vram_data,
            bus.busy, bus.done, bus.overflow, bus.truncated};
    checks++;
    if (outs !== 31'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got %0h want 0", outs);
    end
    n = log_q.size();
    checks++;
    if (n !== 20) begin
      errors++;
      $display("FAIL reset_mid_before: got %0d writes want 20", n);
    end
    repeat (10) tick();
    reset_n = 1'b1;
    repeat (5) tick();
    checks++;
    if (log_q.size() !== n || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_after: got %0d writes busy %0b want %0d 0", log_q.size(), bus.busy, n);
    end
  endtask

  initial begin
    bus.ioctl_download = 1'b0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_data     = 8'h00;
    test_reset();
    test_literal();
    test_repeat();
    test_overflow();
    test_truncation();
    test_end_during_fill();
    test_restart_mid_fill();
    test_reset_mid_fill();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rle_vram_loader.md
Name: rle_vram_loader

Overview:
- Decodes a run-length-encoded monoscope image streamed over the HPS ioctl download port.
- Writes the decoded 8-bit RGB332 pixels, linearly, into the 320x240 VRAM write port read by the 240p suite video generator.
- Sits between hps_io and the VRAM. It throttles the HPS with ioctl_wait while it expands repeat runs.

Parameters:
- AW, 17, VRAM address width.
- PIXELS, 76800, number of valid VRAM locations (320*240). Writes at or beyond this address are suppressed.

Ports:
- clk  in  1  system clock (same clock as the video generator).
- reset_n  in  1  asynchronous, active-low reset.
- ioctl_download  in  1  high for the whole duration of a download.
- ioctl_wr  in  1  one-cycle strobe; ioctl_data is valid in that cycle.
- ioctl_data  in  8  stream byte.
- ioctl_wait  out  1  stall request to the HPS.
- vram_we  out  1  VRAM write enable.
- vram_addr  out  AW  VRAM write address.
- vram_data  out  8  VRAM write data.
- busy  out  1  decoder is not IDLE.
- done  out  1  one-cycle pulse when a download finishes.
- overflow  out  1  sticky: at least one write was suppressed because its address was >= PIXELS.
- truncated  out  1  sticky: the download ended in the middle of a sequence.

Behaviour:
- Reset (reset_n low, asynchronous): every output is 0, state is IDLE, the address counter is 0 and the run counter is 0.
- Stream format: control byte C, followed by its payload.
  - C[7]=0 is a literal run. The next C[6:0]+1 bytes (1..128) are written unchanged.
  - C[7]=1 is a repeat run. The next single byte is written C[6:0]+2 times (2..129).
- FSM states: IDLE, CTRL, LIT, REP_VAL, REP_FILL.
- IDLE:
  - A rising edge on ioctl_download (registered edge detect) moves the FSM to CTRL.
  - On that edge the address counter is set to 0 and overflow and truncated are cleared.
  - ioctl_wr strobes received in IDLE are ignored.
- CTRL:
  - On ioctl_wr, load the run counter from C[6:0], then go to LIT if C[7]=0, otherwise to REP_VAL.
- LIT:
  - Each ioctl_wr accepted in cycle N produces vram_we=1 in cycle N+1, with vram_data equal to the byte and vram_addr equal to the current address. The address then increments.
  - After the last literal byte, return to CTRL.
- REP_VAL:
  - When the value byte is accepted in cycle N, latch it and enter REP_FILL at N+1.
- REP_FILL:
  - For a repeat count n, the block writes one pixel per clock in cycles N+1..N+n.
  - ioctl_wait is high in exactly those cycles. It is decoded combinationally from the state register (state==REP_FILL).
  - The FSM returns to CTRL in cycle N+n+1.
- HPS wait rule: the HPS never strobes ioctl_wr while ioctl_wait is high. If it does, the byte is dropped and truncated is set.
- Address handling:
  - vram_addr advances by 1 per decoded pixel and saturates at PIXELS.
  - A decoded pixel whose address is >= PIXELS gives vram_we=0 and sets overflow. Decoding continues normally.
- Download end (falling edge of ioctl_download):
  - In CTRL: done pulses in the next cycle, then the FSM goes to IDLE.
  - In REP_FILL: the fill completes, then done pulses and the FSM goes to IDLE. truncated is not set.
  - In LIT or REP_VAL: truncated is set, done pulses in the next cycle, then the FSM goes to IDLE.
- A rising edge on ioctl_download while not IDLE restarts the decoder: state CTRL, address 0, flags cleared. No done pulse is generated.
- Reset asserted mid-run aborts the run immediately. No further VRAM writes occur.
- busy = (state != IDLE), registered.

Decomposition:
- Shared package rle_pkg, containing:
  - the state enum;
  - PIXELS;
  - control-byte field constants (RLE_REPEAT_BIT=7, RLE_LEN_MSB=6);
  - the minimum run lengths (LIT_MIN=1, REP_MIN=2).
- One natural sub-module: edge_detect (registered rise/fall of ioctl_download), reused by other loaders.

Test Plan:
- Literal run: start download, send 0x02, AA, BB, CC, end download. Required: three writes, addr 0/1/2, data AA/BB/CC, each one cycle after its strobe. done pulses once; truncated=0.
- Repeat run: send 0x83, 0x1C. Required: five consecutive writes of 0x1C at addr 0..4. ioctl_wait is high for exactly 5 cycles starting the cycle after the value strobe.
- Overflow: fill 76798 pixels, then send 0x84, FF (6 pixels). Required: writes at 76798 and 76799 only. overflow=1 and vram_addr holds 76800.
- Truncation: send 0x05, 11, 22, then drop ioctl_download. Required: two writes, truncated=1, done pulse, busy=0.
- End during fill and reset mid-fill:
  - Drop ioctl_download during a 129-pixel fill. Required: all 129 writes complete before done.
  - Separately, assert reset_n low mid-fill. Required: all outputs go to 0 immediately and no further writes occur.
- Restart: a second download after the first. Required: the address restarts at 0 and the overflow and truncated flags are cleared.
